// File: rtl/cpu_clock_enable.sv
// Turns the divided clock into single-cycle processor enables on the board clock,
// with free-run, debounced single-step and a permanent halt state.
module cpu_clock_enable #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10
) (
   input  logic        clock_in,
   input  logic        reset_n,
   input  logic        slow_clock,
   input  logic        mode_run,
   input  logic        step_button,
   input  logic        halt,
   output logic        cpu_enable,
   output logic        running,
   output logic        halted,
   output logic [15:0] enable_count
);

   typedef enum logic [1:0] {StStep, StRun, StHalt} state_e;

   logic        slow_meta_q, slow_sync_q, slow_prev_q;
   logic        mode_meta_q, mode_sync_q;
   logic        btn_meta_q, btn_sync_q;
   logic [15:0] db_cnt_q, db_cnt_d;
   logic        db_level_q, db_level_d;
   logic        step_req_q, step_req_d;
   logic        step_pending_q, step_pending_d;
   logic        enable_q, enable_d;
   logic [15:0] count_q, count_d;
   state_e      state_q, state_d;
   logic        tick;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         slow_meta_q <= 1'b0;
         slow_sync_q <= 1'b0;
         slow_prev_q <= 1'b0;
         mode_meta_q <= 1'b0;
         mode_sync_q <= 1'b0;
         btn_meta_q  <= 1'b0;
         btn_sync_q  <= 1'b0;
      end else begin
         slow_meta_q <= slow_clock;
         slow_sync_q <= slow_meta_q;
         slow_prev_q <= slow_sync_q;
         mode_meta_q <= mode_run;
         mode_sync_q <= mode_meta_q;
         btn_meta_q  <= step_button;
         btn_sync_q  <= btn_meta_q;
      end
   end

   // Rising edges of the divided clock only.
   assign tick = slow_sync_q & ~slow_prev_q;

   always_comb begin
      db_cnt_d   = '0;
      db_level_d = db_level_q;
      step_req_d = 1'b0;
      if (btn_sync_q != db_level_q) begin
         if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            db_level_d = btn_sync_q;
            step_req_d = btn_sync_q;
         end else begin
            db_cnt_d = db_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      step_pending_d = step_pending_q;
      enable_d       = 1'b0;
      case (state_q)
         StStep: begin
            if (halt) begin
               state_d        = StHalt;
               step_pending_d = 1'b0;
            end else begin
               // A request arriving with a tick waits for the following tick.
               if (tick && step_pending_q) begin
                  enable_d       = 1'b1;
                  step_pending_d = 1'b0;
               end else if (step_req_q) begin
                  step_pending_d = 1'b1;
               end
               if (mode_sync_q) begin
                  state_d        = StRun;
                  step_pending_d = 1'b0;
               end
            end
         end
         StRun: begin
            step_pending_d = 1'b0;
            if (halt) begin
               state_d = StHalt;
            end else begin
               enable_d = tick;
               if (!mode_sync_q) begin
                  state_d = StStep;
               end
            end
         end
         StHalt: begin
            step_pending_d = 1'b0;
         end
         default: begin
            state_d        = StStep;
            step_pending_d = 1'b0;
         end
      endcase
   end

   assign count_d = count_q + {15'd0, enable_d};

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q       <= '0;
         db_level_q     <= 1'b0;
         step_req_q     <= 1'b0;
         step_pending_q <= 1'b0;
         enable_q       <= 1'b0;
         count_q        <= '0;
         state_q        <= StStep;
      end else begin
         db_cnt_q       <= db_cnt_d;
         db_level_q     <= db_level_d;
         step_req_q     <= step_req_d;
         step_pending_q <= step_pending_d;
         enable_q       <= enable_d;
         count_q        <= count_d;
         state_q        <= state_d;
      end
   end

   assign cpu_enable   = enable_q;
   assign running      = (state_q == StRun);
   assign halted       = (state_q == StHalt);
   assign enable_count = count_q;

endmodule

// File: doc/cpu_clock_enable.md
# cpu_clock_enable

Converts the divided clock from the clock divider into single-cycle clock-enable pulses for the processor, so the core runs entirely on the fast board clock. It operates in either free-run or single-step mode. Single-step mode uses a debounced pushbutton. The block also stops issuing enables permanently once the processor signals halt. It sits directly downstream of the clock divider and drives the processor's global enable.

## Interface
- DEBOUNCE_CYCLES, default 16'd10: consecutive stable clock_in cycles required before a button level is accepted (board builds use 16'd50000).
- clock_in  input  1  board clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- slow_clock  input  1  divided clock from the clock divider; treated as asynchronous.
- mode_run  input  1  switch: 1 = free-run, 0 = single-step; asynchronous.
- step_button  input  1  raw pushbutton, active-high, bouncing; asynchronous.
- halt  input  1  processor halt flag; synchronous to clock_in and not re-synchronised.
- cpu_enable  output  1  one-cycle enable pulse to the processor.
- running  output  1  high while the FSM is in RUN.
- halted  output  1  high while the FSM is in HALT.
- enable_count  output  16  number of cpu_enable pulses issued; wraps at 16'hFFFF to 0.

## Operation
- **Synchronisers:** slow_clock, mode_run and step_button each pass through a 2-flop synchroniser.
- **Tick:** tick = sync_slow & ~prev_slow, one cycle per slow_clock rising edge. Falling edges are ignored.
- **Debouncer:**
  - A 16-bit counter increments while the synchronised button differs from the debounced level.
  - On a mismatch the counter clears when the button returns to the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the new value and the counter clears.
  - A debounced 0->1 transition produces a one-cycle step_req.
- **step_pending:**
  - Set by step_req in STEP state.
  - Cleared when its enable issues, or on entering RUN or HALT.
  - Additional step_req pulses while it is set are ignored; there is no queueing.
- **FSM states:** STEP (reset state), RUN, HALT.
- **STEP:**
  - If tick and step_pending are both set: issue cpu_enable and clear step_pending.
  - A step_req in the same cycle as a tick only sets step_pending; it is serviced at the next tick.
  - If sync_mode_run=1: go to RUN and discard step_pending.
- **RUN:**
  - cpu_enable is issued on every tick.
  - If sync_mode_run=0: go to STEP. A tick in that same cycle still issues its enable.
- **Halt:**
  - halt=1 in STEP or RUN: go to HALT. No enable issues in that cycle, even if a tick is present.
  - Halt takes priority over mode change.
- **HALT:** absorbing; it is left only through reset_n. Ticks and button presses are ignored.
- **enable_count:** increments by 1 at each edge where cpu_enable is registered high. It is 16-bit unsigned and wraps.

## Timing
- Reset (asynchronous): all outputs 0 and state = STEP. Synchroniser flops, prev_slow, the debounce counter, the debounced level and step_pending are all cleared.
- Release of reset_n takes effect at the next clock_in edge. An assertion of reset_n mid-pulse forces cpu_enable to 0 immediately.
- **Tick latency:** let k be the first edge at which slow_clock is sampled high after being sampled low.
  - The tick is combinationally high during cycle k+1..k+2.
  - cpu_enable is registered high at edge k+2 and low at edge k+3: exactly one cycle.
- **Mode latency:** a change on mode_run alters the state at edge k+2, where k is the first sampling edge of the new value.
- **Button latency:** the synchronised button goes high at edge k+1. The debounced level rises DEBOUNCE_CYCLES edges later, and step_req follows in the next cycle.
- **Halt latency:** halt high before edge e gives halted=1 and running=0 from edge e. cpu_enable is never high at or after edge e.
- **Output alignment:** running and halted are registered state decodes. enable_count updates at the same edge that cpu_enable rises.

## Test plan
- **Reset, then run:** reset_n low for 3 cycles, mode_run=1, slow_clock toggling every 10 cycles. Expect running=1 after 3 edges, then one cpu_enable per slow_clock rise, each 2 edges after sampling. After 5 rises, enable_count=5.
- **Single step with bounce:** mode_run=0, DEBOUNCE_CYCLES=10. step_button toggles every 3 cycles for 20 cycles, then is held high.
  - Expect exactly one cpu_enable, at the first tick after step_req.
  - Before the press, ticks produce no enables.
  - A second clean press yields enable_count=2.
- **Step request coincident with tick:** step_req lands in the same cycle as a tick. Expect no enable on that tick, an enable on the next tick, and step_pending cleared.
- **Halt priority:** RUN mode, halt=1 in the same cycle as a tick. Expect cpu_enable=0, halted=1 and running=0. Further ticks and mode changes give no enables until reset_n pulses, after which the state returns to STEP with all outputs 0.
- **Counter wrap:** preload via 65535 ticks in RUN. The next enable must give enable_count=0.
- **Mode switch mid-run:** switch mode_run 1->0 with a tick aligned to the transition edge. Expect that enable to issue, then no further enables without a button press.
